// File: rtl/dco_fll_ctrl.sv
// Frequency-locked loop controller: successive-approximation search of an 8-bit DCO code
// against a target edge count per gate window. Define DCO_FLL_TRACK_EN to keep tracking after lock.
module dco_fll_ctrl #(
    parameter int unsigned GATE_CYCLES   = 256,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned TOL           = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] target,
    input  logic       dco_in,
    output logic [7:0] dco_code,
    output logic       busy,
    output logic       locked,
    output logic [7:0] meas_count,
    output logic       meas_valid
);

    localparam int unsigned CODE_W = 8;
    localparam int unsigned CMP_W  = 9;
    localparam int unsigned TMR_W  = 10;
    localparam int unsigned IDX_W  = 3;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETTLE  = 3'd1;
    localparam logic [2:0] ST_MEASURE = 3'd2;
    localparam logic [2:0] ST_UPDATE  = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0]  GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CMP_W-1:0]  TOL_EXT     = CMP_W'(TOL);
    localparam logic [CODE_W-1:0] CODE_MID    = 8'h80;
    localparam logic [CODE_W-1:0] CODE_MAX    = 8'hFF;

    logic [2:0]        state;
    logic [2:0]        state_d;
    logic              sync1;
    logic              sync2;
    logic              sync3;
    logic [TMR_W-1:0]  tmr;
    logic [TMR_W-1:0]  tmr_d;
    logic [CODE_W-1:0] edge_cnt;
    logic [CODE_W-1:0] edge_cnt_d;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_d;
    logic [CODE_W-1:0] dco_code_d;
    logic              busy_d;
    logic              locked_d;
    logic [CODE_W-1:0] meas_count_d;
    logic              meas_valid_d;

    logic              edge_seen_c;
    logic [CMP_W-1:0]  count_ext_c;
    logic [CMP_W-1:0]  target_ext_c;
    logic              too_fast_c;
    logic              too_slow_c;
    logic              trk_fast_c;
    logic              trk_slow_c;
    logic [CODE_W-1:0] code_sa_c;

    // Rising edge of the resynchronised DCO clock
    assign edge_seen_c  = sync2 & ~sync3;
    assign count_ext_c  = {1'b0, edge_cnt};
    assign target_ext_c = {1'b0, target};
    assign too_fast_c   = count_ext_c > target_ext_c;
    assign trk_fast_c   = count_ext_c > (target_ext_c + TOL_EXT);
    assign trk_slow_c   = (count_ext_c + TOL_EXT) < target_ext_c;
    assign too_slow_c   = trk_slow_c && (dco_code != CODE_MAX);

    // Next-state and next-output logic; en low overrides every state
    always_comb begin
        state_d      = state;
        tmr_d        = tmr;
        edge_cnt_d   = edge_cnt;
        idx_d        = idx;
        dco_code_d   = dco_code;
        busy_d       = busy;
        locked_d     = locked;
        meas_count_d = meas_count;
        meas_valid_d = 1'b0;
        code_sa_c    = dco_code;

        if (!en) begin
            state_d  = ST_IDLE;
            tmr_d    = '0;
            busy_d   = 1'b0;
            locked_d = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_d    = ST_SETTLE;
                    tmr_d      = '0;
                    dco_code_d = CODE_MID;
                    idx_d      = IDX_W'(CODE_W - 1);
                    busy_d     = 1'b1;
                    locked_d   = 1'b0;
                end
                ST_SETTLE: begin
                    if (tmr == SETTLE_LAST) begin
                        state_d    = ST_MEASURE;
                        tmr_d      = '0;
                        edge_cnt_d = '0;
                    end else begin
                        tmr_d = tmr + TMR_W'(1);
                    end
                end
                ST_MEASURE: begin
                    if (edge_seen_c && (edge_cnt != CODE_MAX)) begin
                        edge_cnt_d = edge_cnt + CODE_W'(1);
                    end
                    if (tmr == GATE_LAST) begin
                        state_d = ST_UPDATE;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr + TMR_W'(1);
                    end
                end
                ST_UPDATE: begin
                    meas_count_d = edge_cnt;
                    meas_valid_d = 1'b1;
                    tmr_d        = '0;
                    state_d      = ST_SETTLE;
                    if (!locked) begin
                        // Binary search: drop the trial bit if the DCO ran fast
                        if (too_fast_c) begin
                            code_sa_c[idx] = 1'b0;
                        end
                        if (idx != '0) begin
                            code_sa_c[idx - IDX_W'(1)] = 1'b1;
                            idx_d = idx - IDX_W'(1);
                        end else begin
                            state_d  = ST_DONE;
                            busy_d   = 1'b0;
                            locked_d = 1'b1;
                        end
                        dco_code_d = code_sa_c;
                    end else if (trk_fast_c && (dco_code != '0)) begin
                        dco_code_d = dco_code - CODE_W'(1);
                    end else if (too_slow_c) begin
                        dco_code_d = dco_code + CODE_W'(1);
                    end
                end
                ST_DONE: begin
`ifdef DCO_FLL_TRACK_EN
                    state_d = ST_SETTLE;
                    tmr_d   = '0;
`else
                    state_d = ST_DONE;
`endif
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, synchroniser and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync3      <= 1'b0;
            tmr        <= '0;
            edge_cnt   <= '0;
            idx        <= '0;
            dco_code   <= '0;
            busy       <= 1'b0;
            locked     <= 1'b0;
            meas_count <= '0;
            meas_valid <= 1'b0;
        end else begin
            state      <= state_d;
            sync1      <= dco_in;
            sync2      <= sync1;
            sync3      <= sync2;
            tmr        <= tmr_d;
            edge_cnt   <= edge_cnt_d;
            idx        <= idx_d;
            dco_code   <= dco_code_d;
            busy       <= busy_d;
            locked     <= locked_d;
            meas_count <= meas_count_d;
            meas_valid <= meas_valid_d;
        end
    end

endmodule

// File: tb/tb_dco_fll_ctrl.sv
// Self-checking bench for dco_fll_ctrl: closed loop with an accumulator DCO model and a
// successive-approximation reference that tracks expected codes window by window.
module tb_dco_fll_ctrl;

    localparam int SETTLE = 16;
    localparam int GATE   = 256;
    localparam int ITER   = SETTLE + GATE + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [7:0] target;
    logic       dco_in;
    logic [7:0] dco_code;
    logic       busy;
    logic       locked;
    logic [7:0] meas_count;
    logic       meas_valid;

    logic [8:0] acc;
    logic       dco_prev;
    int         dco_edges = 0;
    int         mv_pulses = 0;
    int         n_vec = 0;
    int         n_err = 0;

    dco_fll_ctrl #(
        .GATE_CYCLES  (GATE),
        .SETTLE_CYCLES(SETTLE),
        .TOL          (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .target    (target),
        .dco_in    (dco_in),
        .dco_code  (dco_code),
        .busy      (busy),
        .locked    (locked),
        .meas_count(meas_count),
        .meas_valid(meas_valid)
    );

    always #5 clk = ~clk;

    // DCO: MSB of a 9-bit phase accumulator stepped by the code each clk
    assign dco_in = acc[8];

    always @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            dco_prev <= 1'b0;
        end else begin
            acc      <= acc + {1'b0, dco_code};
            dco_prev <= dco_in;
            if (dco_in && !dco_prev) dco_edges <= dco_edges + 1;
        end
        if (meas_valid === 1'b1) mv_pulses <= mv_pulses + 1;
    end

    task automatic check(input string tag, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic abs_diff(input int a, input int b, output int d);
        d = (a > b) ? a - b : b - a;
    endtask

    // Full acquisition against the reference search; returns the final code
    task automatic acquire(input logic [7:0] tgt, output logic [7:0] fin);
        logic [7:0] m;
        int idx;
        int e0;
        int ref_cnt;
        int p0;
        int d;
        target = tgt;
        en     = 1'b1;
        p0     = mv_pulses;
        step(1);
        check("start_code", int'(dco_code), 128);
        check("start_busy", int'(busy), 1);
        check("start_locked", int'(locked), 0);
        m   = 8'h80;
        idx = 7;
        for (int k = 0; k < 8; k++) begin
            step(SETTLE);
            e0 = dco_edges;
            step(GATE);
            ref_cnt = dco_edges - e0;
            if (k == 7) check("pre_lock_locked", int'(locked), 0);
            step(1);
            check("meas_valid", int'(meas_valid), 1);
            abs_diff(int'(meas_count), ref_cnt, d);
            check("meas_off_by", (d <= 1) ? 0 : d, 0);
            if (int'(meas_count) > int'(tgt)) m[idx] = 1'b0;
            if (idx > 0) m[idx-1] = 1'b1;
            idx--;
            check("code_iter", int'(dco_code), int'(m));
            check("busy_iter", int'(busy), (k < 7) ? 1 : 0);
            check("locked_iter", int'(locked), (k < 7) ? 0 : 1);
        end
        step(20);
        check("mv_pulses", mv_pulses - p0, 8);
        check("code_hold", int'(dco_code), int'(m));
        check("busy_after", int'(busy), 0);
        fin = m;
    endtask

    initial begin
        logic [7:0] fin;
        logic [7:0] c;
        int p0;

        reset  = 1'b1;
        en     = 1'b0;
        target = 8'd0;
        step(2);
        check("rst_code", int'(dco_code), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_meas_count", int'(meas_count), 0);
        check("rst_meas_valid", int'(meas_valid), 0);
        en = 1'b1;
        step(2);
        check("rst_en_busy", int'(busy), 0);
        check("rst_en_code", int'(dco_code), 0);
        en    = 1'b0;
        reset = 1'b0;
        step(1);
        check("idle_busy", int'(busy), 0);

        acquire(8'd64, fin);
        check("lock64_in_set", int'(fin == 8'd128 || fin == 8'd129), 1);
        en = 1'b0; step(1);

        acquire(8'd255, fin);
        check("lock255_code", int'(fin), 255);
        en = 1'b0; step(1);

        acquire(8'd0, fin);
        check("lock0_le1", int'(fin <= 8'd1), 1);
        en = 1'b0; step(1);

        // Drop en mid-acquisition, then restart from the midpoint
        target = 8'd64;
        en     = 1'b1;
        step(600);
        c  = dco_code;
        en = 1'b0;
        step(1);
        check("drop_busy", int'(busy), 0);
        check("drop_locked", int'(locked), 0);
        check("drop_code", int'(dco_code), int'(c));
        check("drop_mv", int'(meas_valid), 0);
        step(5);
        check("drop_code_held", int'(dco_code), int'(c));
        acquire(8'd64, fin);
        en = 1'b0; step(1);

        // Reset in the middle of the third measurement window, en held high
        en = 1'b1;
        step(1);
        step(2 * ITER + SETTLE + 100);
        reset = 1'b1;
        step(1);
        check("midrst_code", int'(dco_code), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_locked", int'(locked), 0);
        check("midrst_meas_count", int'(meas_count), 0);
        check("midrst_mv", int'(meas_valid), 0);
        reset = 1'b0;
        acquire(8'd64, fin);
        en = 1'b0; step(1);

        for (int r = 0; r < 2; r++) begin
            acquire(8'($urandom_range(10, 120)), fin);
            en = 1'b0; step(1);
        end

        acquire(8'd64, fin);
        c      = dco_code;
        target = 8'd70;
`ifdef DCO_FLL_TRACK_EN
        begin
            logic [7:0] last;
            int last_chg;
            int d;
            last     = c;
            last_chg = -1;
            for (int t = 0; t < 30 * ITER; t++) begin
                step(1);
                if (dco_code != last) begin
                    abs_diff(int'(dco_code), int'(last), d);
                    check("trk_step", d, 1);
                    if (last_chg >= 0) check("trk_gap_ok", int'((t - last_chg) >= ITER), 1);
                    last     = dco_code;
                    last_chg = t;
                end
            end
            check("trk_locked", int'(locked), 1);
            check("trk_busy", int'(busy), 0);
            // Dead-band of one edge lets the loop park a code or two either side of 140
            check("trk_final_range", int'(dco_code >= 8'd137 && dco_code <= 8'd143), 1);
        end
`else
        p0 = mv_pulses;
        step(1000);
        check("notrk_code", int'(dco_code), int'(c));
        check("notrk_pulses", mv_pulses - p0, 0);
        check("notrk_locked", int'(locked), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
